// File: rtl/mult_err_pkg.sv
// Shared widths, FSM state and pipeline payload types for the approximate-multiplier
// error-statistics block.
package mult_err_pkg;

    function automatic int unsigned ed_width(input int unsigned w);
        return 2 * w;
    endfunction

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned ED_W  = ed_width(W);
    localparam int unsigned SUM_W = ED_W + CNT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [ED_W-1:0] r_apx;
    } sample_t;

    typedef struct packed {
        logic [ED_W-1:0] ed;
        logic            is_err;
        logic            is_over;
    } err_t;

endpackage

// File: rtl/mult_err_stats_if.sv
// Sample stream from the multiplier under test: operands plus approximate product,
// valid/ready handshake.
interface mult_err_stats_if;
    import mult_err_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    A;
    logic [W-1:0]    B;
    logic [ED_W-1:0] R_apx;

    modport master (output in_valid, A, B, R_apx, input in_ready);
    modport slave  (input in_valid, A, B, R_apx, output in_ready);
endinterface

// File: rtl/err_dist_unit.sv
// Exact product and error distance of one approximate-multiplier sample.
module err_dist_unit
    import mult_err_pkg::*;
(
    input  logic [W-1:0]    A,
    input  logic [W-1:0]    B,
    input  logic [ED_W-1:0] R_apx,
    output logic [ED_W-1:0] exact,
    output logic [ED_W-1:0] ed,
    output logic            is_err,
    output logic            is_over
);

    always_comb begin
        exact   = ED_W'(A) * ED_W'(B);
        is_over = (R_apx > exact);
        ed      = is_over ? (R_apx - exact) : (exact - R_apx);
        is_err  = (ed != '0);
    end

endmodule

// File: rtl/mult_err_stats.sv
// Run controller, two-stage sample pipeline and statistics accumulators for
// characterising an approximate 8x8 multiplier.
module mult_err_stats
    import mult_err_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    mult_err_stats_if.slave  smp,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] over_cnt,
    output logic [ED_W-1:0]  max_ed,
    output logic [SUM_W-1:0] sum_ed
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] target, accepted;
    logic             accept_c, last_c, clear_c;
    logic             s1_v, s2_v;
    sample_t          s1;
    err_t             s2;
    logic [ED_W-1:0]  eu_exact, eu_ed;
    logic             eu_is_err, eu_is_over;
    logic [SUM_W:0]   sum_wide_c;

    assign smp.in_ready = (state == RUN) && (accepted < target);
    assign busy         = (state == RUN) || (state == DRAIN);
    assign done         = (state == DONE);
    assign accept_c     = smp.in_valid && smp.in_ready;
    assign last_c       = accept_c && (accepted == (target - CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // start is only honoured between runs; a zero-length run finishes immediately
    always_comb begin
        state_nxt = state;
        clear_c   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clear_c   = 1'b1;
                    state_nxt = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN:     if (last_c) state_nxt = DRAIN;
            DRAIN:   if (!s1_v && !s2_v) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target   <= '0;
            accepted <= '0;
        end else if (clear_c) begin
            target   <= num_samples;
            accepted <= '0;
        end else if (accept_c) begin
            accepted <= accepted + CNT_W'(1);
        end
    end

    err_dist_unit u_edu (
        .A       (s1.a),
        .B       (s1.b),
        .R_apx   (s1.r_apx),
        .exact   (eu_exact),
        .ed      (eu_ed),
        .is_err  (eu_is_err),
        .is_over (eu_is_over)
    );

    // over-estimate flag must agree with the exact product it was derived from
    assert property (@(posedge clk) disable iff (rst)
        s1_v |-> (eu_is_over == (s1.r_apx > eu_exact)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1   <= '0;
            s2_v <= 1'b0;
            s2   <= '0;
        end else begin
            s1_v <= accept_c;
            if (accept_c) s1 <= '{a: smp.A, b: smp.B, r_apx: smp.R_apx};
            s2_v <= s1_v;
            if (s1_v) s2 <= '{ed: eu_ed, is_err: eu_is_err, is_over: eu_is_over};
        end
    end

    assign sum_wide_c = {1'b0, sum_ed} + (SUM_W+1)'(s2.ed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            over_cnt   <= '0;
            max_ed     <= '0;
            sum_ed     <= '0;
        end else if (clear_c) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            over_cnt   <= '0;
            max_ed     <= '0;
            sum_ed     <= '0;
        end else if (s2_v) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (s2.is_err)     err_cnt  <= err_cnt + CNT_W'(1);
            if (s2.is_over)    over_cnt <= over_cnt + CNT_W'(1);
            if (s2.ed > max_ed) max_ed  <= s2.ed;
            sum_ed <= sum_wide_c[SUM_W] ? '1 : sum_wide_c[SUM_W-1:0];
        end
    end

endmodule

// File: tb/tb_mult_err_stats.sv
// Directed bench for mult_err_stats: an event-level reference model plus
// hand-computed checkpoints for each scenario.
module tb_mult_err_stats;
    import mult_err_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;
    logic             busy, done;
    logic [CNT_W-1:0] sample_cnt, err_cnt, over_cnt;
    logic [ED_W-1:0]  max_ed;
    logic [SUM_W-1:0] sum_ed;

    mult_err_stats_if smp ();

    mult_err_stats dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .smp         (smp),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .over_cnt    (over_cnt),
        .max_ed      (max_ed),
        .sum_ed      (sum_ed)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: each accepted sample is stored with the edge it was taken on;
    // statistics are whatever has been accepted at least two edges ago.
    typedef struct {
        int ed;
        bit over;
        int e;
    } rec_t;

    rec_t q[$];
    bit   run_on = 0;
    int   tgt = 0, acc_n = 0, last_e = -10, edge_n = 0;

    function automatic bit m_ready();
        return run_on && (acc_n < tgt);
    endfunction

    function automatic bit m_done(input int k);
        return run_on && ((tgt == 0) || ((acc_n == tgt) && (k >= last_e + 3)));
    endfunction

    always @(posedge clk) begin
        int ex, r;
        if (rst) begin
            run_on = 0; q.delete(); acc_n = 0; tgt = 0;
        end else if (start && (!run_on || m_done(edge_n - 1))) begin
            q.delete(); run_on = 1; tgt = int'(num_samples); acc_n = 0; last_e = -10;
        end else if (smp.in_valid && m_ready()) begin
            ex = int'(smp.A) * int'(smp.B);
            r  = int'(smp.R_apx);
            q.push_back('{(ex >= r) ? ex - r : r - ex, r > ex, edge_n});
            acc_n++;
            last_e = edge_n;
        end
        edge_n++;
    end

    always @(negedge clk) begin
        int k, cnt, err, ovr, mx;
        longint sum;
        if (!rst) begin
            k = edge_n - 1;
            cnt = 0; err = 0; ovr = 0; mx = 0; sum = 0;
            foreach (q[i]) begin
                if (q[i].e <= k - 2) begin
                    cnt++;
                    if (q[i].ed != 0) err++;
                    if (q[i].over) ovr++;
                    if (q[i].ed > mx) mx = q[i].ed;
                    sum += q[i].ed;
                end
            end
            if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
            chk("in_ready",   smp.in_ready, m_ready());
            chk("busy",       busy, run_on && !m_done(k));
            chk("done",       done, m_done(k));
            chk("sample_cnt", sample_cnt, cnt);
            chk("err_cnt",    err_cnt, err);
            chk("over_cnt",   over_cnt, ovr);
            chk("max_ed",     max_ed, mx);
            chk("sum_ed",     sum_ed, sum);
        end
    end

    task automatic start_run(input int n);
        num_samples = CNT_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input int a, input int b, input int r);
        int  n0 = acc_n;
        bit  got = 0;
        smp.in_valid = 1'b1;
        smp.A = W'(a); smp.B = W'(b); smp.R_apx = ED_W'(r);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (acc_n != n0) got = 1;
        end
        smp.in_valid = 1'b0;
        if (!got) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        bit [5:0] pat;
        int       lat;
        smp.in_valid = 1'b0; smp.A = '0; smp.B = '0; smp.R_apx = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", smp.in_ready, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // single exact sample
        start_run(1);
        push(3, 5, 15);
        wait_done();
        chk("t1_sample_cnt", sample_cnt, 1);
        chk("t1_sum", sum_ed, 0);
        chk("t1_max", max_ed, 0);
        chk("t1_err", err_cnt, 0);
        chk("t1_over", over_cnt, 0);

        // one over-estimate, one under-estimate
        start_run(2);
        push(255, 255, 16'hFF00);
        push(16, 16, 16'h00F0);
        wait_done();
        chk("t2_sum", sum_ed, 271);
        chk("t2_max", max_ed, 255);
        chk("t2_err", err_cnt, 2);
        chk("t2_over", over_cnt, 1);
        chk("t2_sample_cnt", sample_cnt, 2);

        // gappy in_valid: 1,0,0,1,0,1
        start_run(3);
        pat = 6'b101001;
        for (int i = 0; i < 6; i++) begin
            smp.in_valid = pat[i];
            smp.A = W'(i + 1); smp.B = W'(i + 2); smp.R_apx = ED_W'(i * 7);
            @(negedge clk);
        end
        smp.in_valid = 1'b0;
        chk("t3_accepts", acc_n, 3);
        chk("t3_ready_low", smp.in_ready, 0);
        lat = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            lat++;
        end
        chk("t3_done_latency", lat, 3);

        // zero-length run
        start_run(0);
        chk("t4_done", done, 1);
        chk("t4_in_ready", smp.in_ready, 0);
        chk("t4_sample_cnt", sample_cnt, 0);
        chk("t4_sum", sum_ed, 0);

        // start during RUN must be ignored
        start_run(4);
        push(10, 10, 100);
        push(7, 9, 60);
        num_samples = CNT_W'(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        push(200, 3, 610);
        push(1, 1, 0);
        wait_done();
        chk("t5_sample_cnt", sample_cnt, 4);
        chk("t5_sum", sum_ed, 14);
        chk("t5_max", max_ed, 10);
        chk("t5_err", err_cnt, 3);
        chk("t5_over", over_cnt, 1);

        // start from DONE clears and reruns
        start_run(1);
        chk("t5b_cleared_cnt", sample_cnt, 0);
        chk("t5b_cleared_sum", sum_ed, 0);
        push(2, 2, 5);
        wait_done();
        chk("t5b_sum", sum_ed, 1);
        chk("t5b_over", over_cnt, 1);

        // async reset mid-run
        start_run(5);
        push(4, 4, 16);
        push(9, 9, 80);
        repeat (3) @(negedge clk);
        chk("t6_pre_cnt", sample_cnt, 2);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_in_ready", smp.in_ready, 0);
        chk("t6_sample_cnt", sample_cnt, 0);
        chk("t6_err", err_cnt, 0);
        chk("t6_max", max_ed, 0);
        chk("t6_sum", sum_ed, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
